// File: rtl/round_ctrl_pkg.sv
// Shared definitions for the round sequencer: state codes, digit limits and
// the minimum round time used when ROUND_CTRL_SPEEDUP_EN is defined.
package round_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  localparam int SPEEDUP_MIN_SECS = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v);
    return (v > MAX_DIGIT) ? MAX_DIGIT : v;
  endfunction

endpackage

// File: rtl/round_ctrl_sec_tick.sv
// Brings the 1 Hz square wave into the fast domain and turns each rising edge
// into a single-cycle tick, registered so it lands 3 cycles after the edge.
module sec_tick (
  input  logic clk,
  input  logic rst,
  input  logic slow_in,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic tick_q,  tick_d;

  // Synchronizer chain, history flop and edge detect.
  always_comb begin
    sync1_d = slow_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  // Flop bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer for the counter game: fetch target, steer guess against a
// seconds countdown, judge, hold result. Optional macro: ROUND_CTRL_SPEEDUP_EN.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int ROUND_SECS = 9,
  parameter int HOLD_SECS  = 2,
  parameter int WIN_SCORE  = 9
) (
  input  logic               Clk100M,
  input  logic               reset,
  input  logic               Clk1Hz,
  input  logic               upB,
  input  logic               downB,
  input  logic               startB,
  output logic               targetReq,
  input  logic               targetValid,
  input  logic [DIGIT_W-1:0] targetIn,
  output logic [DIGIT_W-1:0] guess,
  output logic [DIGIT_W-1:0] target,
  output logic [DIGIT_W-1:0] timeLeft,
  output logic [DIGIT_W-1:0] score,
  output logic [2:0]         state,
  output logic               roundWin,
  output logic               roundLose
);

  localparam logic [DIGIT_W-1:0] HOLD_LOAD = 4'(HOLD_SECS);
  localparam logic [DIGIT_W-1:0] WIN_CAP   = 4'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] guess_q, guess_d;
  logic [DIGIT_W-1:0] target_q, target_d;
  logic [DIGIT_W-1:0] time_q, time_d;
  logic [DIGIT_W-1:0] score_q, score_d;
  logic [DIGIT_W-1:0] hold_q, hold_d;
  logic               req_q, req_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               tick_s;
  logic [DIGIT_W-1:0] round_time_s;

  sec_tick u_sec_tick (
    .clk     (Clk100M),
    .rst     (reset),
    .slow_in (Clk1Hz),
    .tick    (tick_s)
  );

`ifdef ROUND_CTRL_SPEEDUP_EN
  localparam int RT_FLOOR = (ROUND_SECS < SPEEDUP_MIN_SECS) ? ROUND_SECS : SPEEDUP_MIN_SECS;
  int rt_int_s;

  // Rounds shorten as the score climbs, never below the floor.
  always_comb begin
    rt_int_s = ROUND_SECS - int'(score_q);
    if (rt_int_s < RT_FLOOR) begin
      round_time_s = 4'(RT_FLOOR);
    end else begin
      round_time_s = 4'(rt_int_s);
    end
  end
`else
  assign round_time_s = 4'(ROUND_SECS);
`endif

  // Next-state and datapath updates; startB takes priority over a tick in PLAY.
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    target_d = target_q;
    time_d   = time_q;
    score_d  = score_q;
    hold_d   = hold_q;
    req_d    = 1'b0;
    win_d    = 1'b0;
    lose_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startB) begin
          score_d = 4'd0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (targetValid) begin
          target_d = clamp_digit(targetIn);
          guess_d  = 4'd0;
          time_d   = round_time_s;
          state_d  = ST_PLAY;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (startB) begin
          hold_d = HOLD_LOAD;
          if (guess_q == target_q) begin
            win_d   = 1'b1;
            score_d = score_q + 4'd1;
            state_d = ST_WIN;
          end else begin
            lose_d  = 1'b1;
            state_d = ST_LOSE;
          end
        end else begin
          if (tick_s) begin
            if (time_q <= 4'd1) begin
              time_d  = 4'd0;
              lose_d  = 1'b1;
              hold_d  = HOLD_LOAD;
              state_d = ST_LOSE;
            end else begin
              time_d = time_q - 4'd1;
            end
          end else begin
            time_d = time_q;
          end
          if (upB && !downB) begin
            guess_d = (guess_q < MAX_DIGIT) ? guess_q + 4'd1 : guess_q;
          end else if (downB && !upB) begin
            guess_d = (guess_q > 4'd0) ? guess_q - 4'd1 : guess_q;
          end else begin
            guess_d = guess_q;
          end
        end
      end
      ST_WIN: begin
        if (hold_q == 4'd0) begin
          state_d = (score_q == WIN_CAP) ? ST_OVER : ST_FETCH;
        end else if (tick_s) begin
          hold_d = hold_q - 4'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_LOSE: begin
        if (hold_q == 4'd0) begin
          state_d = ST_OVER;
        end else if (tick_s) begin
          hold_d = hold_q - 4'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_OVER: begin
        if (startB) begin
          score_d = 4'd0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      guess_q  <= 4'd0;
      target_q <= 4'd0;
      time_q   <= 4'd0;
      score_q  <= 4'd0;
      hold_q   <= 4'd0;
      req_q    <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      target_q <= target_d;
      time_q   <= time_d;
      score_q  <= score_d;
      hold_q   <= hold_d;
      req_q    <= req_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  assign targetReq = req_q;
  assign guess     = guess_q;
  assign target    = target_q;
  assign timeLeft  = time_q;
  assign score     = score_q;
  assign state     = state_q;
  assign roundWin  = win_q;
  assign roundLose = lose_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: directed test-plan scenarios plus random
// rounds, compared against an event-level game model.
module tb_round_ctrl;

  localparam int ROUND_SECS = 9;
  localparam int HOLD_SECS  = 2;
  localparam int WIN_SCORE  = 9;
  localparam int S_IDLE = 0, S_FETCH = 1, S_PLAY = 2, S_WIN = 3, S_LOSE = 4, S_OVER = 5;

  logic       clk = 1'b0;
  logic       rst, clk1hz, up_b, down_b, start_b, valid_b;
  logic [3:0] tin;
  logic       req, rwin, rlose;
  logic [3:0] guess, target, time_left, score;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int win_seen = 0;
  int lose_seen = 0;
  int m_state, m_guess, m_target, m_time, m_score, m_hold, m_win, m_lose;

  always #5 clk = ~clk;

  round_ctrl #(.ROUND_SECS(ROUND_SECS), .HOLD_SECS(HOLD_SECS), .WIN_SCORE(WIN_SCORE)) dut (
    .Clk100M(clk), .reset(rst), .Clk1Hz(clk1hz), .upB(up_b), .downB(down_b),
    .startB(start_b), .targetReq(req), .targetValid(valid_b), .targetIn(tin),
    .guess(guess), .target(target), .timeLeft(time_left), .score(score),
    .state(state), .roundWin(rwin), .roundLose(rlose)
  );

  // Count every cycle a result pulse is high.
  always @(posedge clk) begin
    if (rwin) win_seen <= win_seen + 1;
    if (rlose) lose_seen <= lose_seen + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int round_time(input int sc);
`ifdef ROUND_CTRL_SPEEDUP_EN
    int fl;
    fl = (ROUND_SECS < 3) ? ROUND_SECS : 3;
    return (ROUND_SECS - sc < fl) ? fl : ROUND_SECS - sc;
`else
    return ROUND_SECS + 0 * sc;
`endif
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_guess = 0; m_target = 0; m_time = 0; m_score = 0; m_hold = 0;
  endtask

  // Game rules applied to one event; result holds resolve immediately.
  task automatic model_event(input bit up, input bit down, input bit start,
                             input bit valid, input int tv, input bit tick);
    case (m_state)
      S_IDLE, S_OVER: if (start) begin m_score = 0; m_state = S_FETCH; end
      S_FETCH: if (valid) begin
        m_target = (tv > 9) ? 9 : tv; m_guess = 0;
        m_time = round_time(m_score); m_state = S_PLAY;
      end
      S_PLAY: begin
        if (start) begin
          m_hold = HOLD_SECS;
          if (m_guess == m_target) begin m_win++; m_score++; m_state = S_WIN; end
          else begin m_lose++; m_state = S_LOSE; end
        end else begin
          if (tick) begin
            if (m_time <= 1) begin m_time = 0; m_lose++; m_hold = HOLD_SECS; m_state = S_LOSE; end
            else m_time--;
          end
          if (up && !down && m_guess < 9) m_guess++;
          else if (down && !up && m_guess > 0) m_guess--;
        end
      end
      S_WIN, S_LOSE: if (tick && m_hold > 0) m_hold--;
      default: ;
    endcase
    if ((m_state == S_WIN || m_state == S_LOSE) && m_hold == 0)
      m_state = (m_state == S_WIN && m_score != WIN_SCORE) ? S_FETCH : S_OVER;
  endtask

  task automatic compare_all(input bit settled);
    check_eq("state", state, m_state);
    check_eq("guess", guess, m_guess);
    check_eq("target", target, m_target);
    check_eq("timeLeft", time_left, m_time);
    check_eq("score", score, m_score);
    if (settled) begin
      check_eq("targetReq", req, (m_state == S_FETCH) ? 1 : 0);
      check_eq("roundWin_count", win_seen, m_win);
      check_eq("roundLose_count", lose_seen, m_lose);
    end
  endtask

  task automatic do_cycle(input bit up, input bit down, input bit start,
                          input bit valid, input logic [3:0] tv);
    @(negedge clk);
    up_b = up; down_b = down; start_b = start; valid_b = valid; tin = tv;
    @(posedge clk); #1;
    up_b = 1'b0; down_b = 1'b0; start_b = 1'b0; valid_b = 1'b0; tin = 4'd0;
    model_event(up, down, start, valid, int'(tv), 1'b0);
    compare_all(1'b0);
    repeat (2) @(posedge clk);
    #1 compare_all(1'b1);
  endtask

  task automatic do_tick();
    @(negedge clk) clk1hz = 1'b1;
    repeat (8) @(negedge clk);
    clk1hz = 1'b0;
    repeat (3) @(negedge clk);
    model_event(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    compare_all(1'b1);
  endtask

  // startB lands on the same edge as the tick (3 cycles after the 1 Hz edge).
  task automatic do_race();
    @(negedge clk) clk1hz = 1'b1;
    repeat (3) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    repeat (6) @(negedge clk);
    clk1hz = 1'b0;
    repeat (3) @(negedge clk);
    model_event(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    compare_all(1'b1);
  endtask

  task automatic steer();
    for (int k = 0; k < 10 && m_guess < m_target; k++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 10 && m_guess > m_target; k++) do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic finish_hold();
    for (int k = 0; k < 5 && (m_state == S_WIN || m_state == S_LOSE); k++) do_tick();
  endtask

  initial begin
    rst = 1'b1; clk1hz = 1'b0; up_b = 1'b0; down_b = 1'b0; start_b = 1'b0;
    valid_b = 1'b0; tin = 4'd0;
    m_win = 0; m_lose = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all(1'b1);
    rst = 1'b0;

    // Stray target and buttons in IDLE are ignored.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    // Correct submit: target 3, three ups.
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    repeat (3) do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_eq("win_score", score, 1);
    finish_hold();
    // Clamp, saturation, simultaneous up/down, wrong submit.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd12);
    check_eq("clamp_target", target, 9);
    repeat (12) do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("sat_high", guess, 9);
    repeat (10) do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check_eq("sat_low", guess, 0);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    finish_hold();
    check_eq("lose_to_over", state, S_OVER);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    // Timeout round.
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    for (int k = 0; k < 20 && m_state == S_PLAY; k++) do_tick();
    check_eq("timeout_time", time_left, 0);
    finish_hold();
    // Full game to WIN_SCORE, with a race on one round.
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int r = 0; r < WIN_SCORE; r++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
`ifdef ROUND_CTRL_SPEEDUP_EN
      if (r == 7) check_eq("speedup_time", time_left, 3);
`else
      if (r == 7) check_eq("fixed_time", time_left, 9);
`endif
      steer();
      if (r == 4) begin
        for (int k = 0; k < 20 && m_time > 1; k++) do_tick();
        do_race();
      end else begin
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      end
      finish_hold();
    end
    check_eq("game_won_state", state, S_OVER);
    check_eq("game_won_score", score, WIN_SCORE);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    // Asynchronous reset in PLAY, between clock edges.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk); #2 rst = 1'b1;
    #1 model_reset();
    compare_all(1'b1);
    @(negedge clk) rst = 1'b0;
    // Random rounds.
    for (int r = 0; r < 20; r++) begin
      int n_ops, fin;
      if (m_state == S_IDLE || m_state == S_OVER) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      repeat ($urandom_range(0, 2)) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
      n_ops = $urandom_range(0, 10);
      for (int k = 0; k < n_ops; k++) begin
        case ($urandom_range(0, 3))
          0: do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
          1: do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
          2: do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
          default: if (m_time > 2) do_tick(); else do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        endcase
      end
      fin = $urandom_range(0, 2);
      if (fin == 0) begin
        for (int k = 0; k < 20 && m_state == S_PLAY; k++) do_tick();
      end else begin
        if (fin == 1) steer();
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      end
      finish_hold();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
